uart_rx_deser: RTL and testbench

Serial UART receiver: deserialises the asynchronous 8N1 stream on the board `uart_rxd` pin into bytes for the CPU-side console peripheral. It is the receiving end of the 8N1 framing the board bench drives into `uart_rxd`: idle-high line, one start bit, 8 data bits LSB first, one stop bit. It uses 16x oversampling from a programmable clock prescaler and checks start-bit validity and stop-bit framing. A one-byte holding register with a valid/ready handshake feeds the Wishbone UART register block, which also consumes the error pulses.

---
 rtl/uart_rx_deser_if.sv | 31 +++
 rtl/uart_rx_deser.sv | 147 ++++++++++++++
 tb/tb_uart_rx_deser.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deser_if.sv
// Receive-side byte channel between the UART deserialiser and its consumer.
// Latency: none, wires only.
// Backpressure: rx_ready from the consumer; error pulses are fire-and-forget.
interface uart_rx_deser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_ferr;
   logic       rx_ovr;
   logic       rx_busy;

   // Receiver side: produces the byte, status and error pulses.
   modport master (
      output rx_data,
      output rx_valid,
      output rx_ferr,
      output rx_ovr,
      output rx_busy,
      input  rx_ready
   );

   // Consumer side: takes the byte and observes status and errors.
   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_ferr,
      input  rx_ovr,
      input  rx_busy,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, one-byte holding register.
// Latency: rx_valid rises 152*OVS_DIV+4 clocks after the start-bit fall on rxd.
// Backpressure: full holding register keeps its byte; a byte completing then is dropped with rx_ovr.
module uart_rx_deser #(
   parameter int unsigned OVS_DIV = 27
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            rxd,
   uart_rx_deser_if.master rx_if
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] PRE_MAX = 16'(OVS_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_sync1;
   logic        r_rxs;
   logic        r_rxs_prev;
   logic [15:0] r_pre;
   logic [7:0]  r_tcnt;
   logic        r_tick;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_ferr;
   logic        r_ovr;
   logic        w_fall;
   logic        w_mid;
   logic        w_shift_en;
   logic        w_stop_evt;
   logic        w_accept;

   // Start edge: previous synchronised level high, current low.
   assign w_fall   = r_rxs_prev & ~r_rxs;
   // Mid-bit strobe: first cycle after the tick count reaches 16n+8.
   assign w_mid    = r_tick & (r_tcnt[3:0] == 4'd8);
   assign w_accept = r_valid & rx_if.rx_ready;

   // Two-flop synchroniser plus previous-level flop, all idling high.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync1    <= 1'b1;
         r_rxs      <= 1'b1;
         r_rxs_prev <= 1'b1;
      end else begin
         r_sync1    <= rxd;
         r_rxs      <= r_sync1;
         r_rxs_prev <= r_rxs;
      end
   end

   // Prescaler and tick counter; held at zero while idle so a frame always starts from a clean phase.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_pre  <= '0;
         r_tcnt <= '0;
         r_tick <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_pre  <= '0;
         r_tcnt <= '0;
         r_tick <= 1'b0;
      end else if (r_pre == PRE_MAX) begin
         r_pre  <= '0;
         r_tcnt <= r_tcnt + 8'd1;
         r_tick <= 1'b1;
      end else begin
         r_pre  <= r_pre + 16'd1;
         r_tick <= 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state and per-cycle strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_stop_evt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) w_state_nxt = S_START;
         end
         S_START: begin
            // A start bit that is high again at its middle was a glitch.
            if (w_mid) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_mid) begin
               w_shift_en = 1'b1;
               if (r_tcnt == 8'd136) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Back to idle on the stop sample so a back-to-back start is seen next clock.
            if (w_mid) begin
               w_stop_evt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Data shift register, LSB first.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)        r_shift <= '0;
      else if (w_shift_en) r_shift <= {r_rxs, r_shift[7:1]};
   end

   // Holding register, handshake and error pulses.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         if (w_accept) r_valid <= 1'b0;
         if (w_stop_evt) begin
            if (!r_rxs) begin
               r_ferr <= 1'b1;
            end else if (!r_valid || w_accept) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end
      end
   end

   assign rx_if.rx_data  = r_data;
   assign rx_if.rx_valid = r_valid;
   assign rx_if.rx_ferr  = r_ferr;
   assign rx_if.rx_ovr   = r_ovr;
   assign rx_if.rx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser at OVS_DIV=27, 20 ns clock, frames sent at 434 clocks per bit.
// Bytes are pushed to a scoreboard when sent and popped on each accept handshake.
// Error pulses and valid rises are counted by a monitor and checked per frame.
module tb_uart_rx_deser;

   localparam int BT = 434;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;
   logic rxd      = 1'b1;

   uart_rx_deser_if u_if ();

   uart_rx_deser #(.OVS_DIV(27)) u_dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .rxd      (rxd),
      .rx_if    (u_if)
   );

   initial forever #10 wb_clk_i = ~wb_clk_i;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         t_fall   = 0;
   int         n_ferr   = 0;
   int         n_ovr    = 0;
   int         n_vrise  = 0;
   int         n_hs     = 0;
   logic       prev_v   = 1'b0;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] dat;
      logic       stop;
      int         idle;
      int         exp_byte;
      int         exp_ferr;
   } vec_t;

   vec_t tbl[6];

   always @(posedge wb_clk_i) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: counts pulses/valid rises and scores every accept handshake.
   always @(negedge wb_clk_i) begin
      if (u_if.rx_valid && !prev_v) n_vrise++;
      prev_v = u_if.rx_valid;
      if (u_if.rx_ferr) n_ferr++;
      if (u_if.rx_ovr)  n_ovr++;
      if (u_if.rx_valid && u_if.rx_ready && !wb_rst_i) begin
         n_hs++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got byte %0h, expected none", u_if.rx_data);
         end else begin
            chk("sb_byte", {24'd0, u_if.rx_data}, {24'd0, sb.pop_front()});
         end
      end
   end

   // Run limit so the bench never hangs.
   initial begin
      repeat (95000) @(posedge wb_clk_i);
      $display("FAIL watchdog: cycle limit reached at %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int idle);
      rxd = 1'b0;
      t_fall = cyc;
      repeat (BT) step();
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BT) step();
      end
      rxd = stop;
      repeat (BT) step();
      rxd = 1'b1;
      repeat (idle) step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"},  {24'd0, u_if.rx_data}, 32'h00);
      chk({tag, "_valid"}, {31'd0, u_if.rx_valid}, 32'd0);
      chk({tag, "_ferr"},  {31'd0, u_if.rx_ferr},  32'd0);
      chk({tag, "_ovr"},   {31'd0, u_if.rx_ovr},   32'd0);
      chk({tag, "_busy"},  {31'd0, u_if.rx_busy},  32'd0);
   endtask

   initial begin
      int f0, o0, v0, h0, lat, k;
      logic seen;

      tbl[0] = '{dat: 8'h54, stop: 1'b1, idle: 0,   exp_byte: 1, exp_ferr: 0};
      tbl[1] = '{dat: 8'h45, stop: 1'b1, idle: 0,   exp_byte: 1, exp_ferr: 0};
      tbl[2] = '{dat: 8'h53, stop: 1'b1, idle: 0,   exp_byte: 1, exp_ferr: 0};
      tbl[3] = '{dat: 8'h54, stop: 1'b1, idle: BT,  exp_byte: 1, exp_ferr: 0};
      tbl[4] = '{dat: 8'h3C, stop: 1'b0, idle: BT,  exp_byte: 0, exp_ferr: 1};
      tbl[5] = '{dat: 8'h11, stop: 1'b1, idle: BT,  exp_byte: 1, exp_ferr: 0};

      // Reset values.
      u_if.rx_ready = 1'b0;
      repeat (5) step();
      chk_reset_outputs("rst0");
      wb_rst_i = 1'b0;
      repeat (20) step();

      // Single frame with rx_ready low: latency and held data.
      f0 = n_ferr; o0 = n_ovr;
      sb.push_back(8'h54);
      lat  = 0;
      seen = 1'b0;
      fork
         send_frame(8'h54, 1'b1, BT);
         begin
            k = 0;
            @(negedge wb_clk_i);
            while (!u_if.rx_valid && k < 6000) begin
               @(negedge wb_clk_i);
               k++;
            end
            seen = u_if.rx_valid;
            lat  = cyc - t_fall;
         end
      join
      chk("t1_valid_seen", {31'd0, seen}, 32'd1);
      n_checks++;
      if (lat < 4105 || lat > 4111) begin
         n_fail++;
         $display("FAIL t1_latency: got %0d clocks, expected 4108 +/- 3", lat);
      end
      chk("t1_data", {24'd0, u_if.rx_data}, 32'h54);
      chk("t1_valid_held", {31'd0, u_if.rx_valid}, 32'd1);
      chk("t1_ferr", n_ferr - f0, 0);
      chk("t1_ovr",  n_ovr - o0, 0);
      u_if.rx_ready = 1'b1;
      repeat (3) step();
      chk("t1_drained", sb.size(), 0);
      chk("t1_valid_clr", {31'd0, u_if.rx_valid}, 32'd0);

      // Table: "TEST" back to back, then a framing error and recovery.
      for (int i = 0; i < 6; i++) begin
         f0 = n_ferr; o0 = n_ovr; v0 = n_vrise;
         if (tbl[i].exp_byte != 0) sb.push_back(tbl[i].dat);
         send_frame(tbl[i].dat, tbl[i].stop, tbl[i].idle);
         chk($sformatf("vec%0d_ferr", i), n_ferr - f0, tbl[i].exp_ferr);
         chk($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
         chk($sformatf("vec%0d_vrise", i), n_vrise - v0, tbl[i].exp_byte);
         chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
      end

      // Glitch on the start bit, then a good frame.
      f0 = n_ferr; o0 = n_ovr; v0 = n_vrise;
      rxd = 1'b0;
      repeat (50) step();
      chk("gl_busy_during", {31'd0, u_if.rx_busy}, 32'd1);
      repeat (50) step();
      rxd = 1'b1;
      repeat (400) step();
      chk("gl_busy_after", {31'd0, u_if.rx_busy}, 32'd0);
      chk("gl_vrise", n_vrise - v0, 0);
      chk("gl_ferr", n_ferr - f0, 0);
      chk("gl_ovr", n_ovr - o0, 0);
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, BT);
      chk("gl_a5_sb_empty", sb.size(), 0);
      chk("gl_a5_vrise", n_vrise - v0, 1);

      // Overrun: two frames with nobody draining.
      u_if.rx_ready = 1'b0;
      f0 = n_ferr; o0 = n_ovr; h0 = n_hs;
      sb.push_back(8'h01);
      send_frame(8'h01, 1'b1, 0);
      send_frame(8'h02, 1'b1, BT);
      chk("ovr_data_kept", {24'd0, u_if.rx_data}, 32'h01);
      chk("ovr_valid", {31'd0, u_if.rx_valid}, 32'd1);
      chk("ovr_pulses", n_ovr - o0, 1);
      chk("ovr_ferr", n_ferr - f0, 0);
      u_if.rx_ready = 1'b1;
      repeat (3) step();
      chk("ovr_handshakes", n_hs - h0, 1);
      chk("ovr_valid_clr", {31'd0, u_if.rx_valid}, 32'd0);
      chk("ovr_sb_empty", sb.size(), 0);

      // Reset in the middle of data bit 4; remaining bits are high so no false start follows.
      f0 = n_ferr; o0 = n_ovr; v0 = n_vrise;
      fork
         send_frame(8'hF0, 1'b1, BT);
         begin
            repeat (BT * 5 + 200) step();
            chk("rs_busy_before", {31'd0, u_if.rx_busy}, 32'd1);
            wb_rst_i = 1'b1;
            step();
            chk_reset_outputs("rs_mid");
            repeat (9) step();
            wb_rst_i = 1'b0;
         end
      join
      chk("rs_vrise", n_vrise - v0, 0);
      chk("rs_ferr", n_ferr - f0, 0);
      chk("rs_ovr", n_ovr - o0, 0);
      sb.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, BT);
      chk("rs_7e_sb_empty", sb.size(), 0);
      chk("rs_7e_vrise", n_vrise - v0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
